// File: rtl/unidad_logica_secuenciador_pkg.sv
// Shared types and constants for the logic-unit sequencer.
package unidad_logica_secuenciador_pkg;

   localparam int unsigned LU_W     = 8;
   localparam int unsigned LU_ZW    = 16;
   localparam int unsigned LU_N_OPS = 6;
   localparam int unsigned LU_SEL_W = 3;

   typedef enum logic [1:0] {
      LU_ST_IDLE  = 2'd0,
      LU_ST_RUN   = 2'd1,
      LU_ST_DRAIN = 2'd2
   } lu_state_e;

   localparam logic [LU_SEL_W-1:0] LU_SEL_0 = 3'd0;
   localparam logic [LU_SEL_W-1:0] LU_SEL_1 = 3'd1;
   localparam logic [LU_SEL_W-1:0] LU_SEL_2 = 3'd2;
   localparam logic [LU_SEL_W-1:0] LU_SEL_3 = 3'd3;
   localparam logic [LU_SEL_W-1:0] LU_SEL_4 = 3'd4;
   localparam logic [LU_SEL_W-1:0] LU_SEL_5 = 3'd5;

   // One-hot mask bit for a select code; codes outside the op range map to zero.
   function automatic logic [LU_N_OPS-1:0] lu_sel_onehot(input logic [LU_SEL_W-1:0] sel);
      logic [LU_N_OPS-1:0] oh;
      oh = '0;
      for (int unsigned k = 0; k < LU_N_OPS; k++) begin
         oh[k] = (sel == LU_SEL_W'(k));
      end
      return oh;
   endfunction

endpackage

// File: rtl/unidad_logica_secuenciador_prio_enc.sv
// Lowest-set-bit encoder: op mask -> select index plus "any bit set" flag.
module lu_sel_prio_enc
   import unidad_logica_secuenciador_pkg::*;
(
   input  logic [LU_N_OPS-1:0] mask_i,
   output logic [LU_SEL_W-1:0] idx_c_o,
   output logic                any_c_o
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx_c_o = '0;
      any_c_o = |mask_i;
      for (int k = int'(LU_N_OPS) - 1; k >= 0; k--) begin
         if (mask_i[k]) idx_c_o = LU_SEL_W'(k);
      end
   end

endmodule

// File: rtl/unidad_logica_secuenciador.sv
// Sequencer driving the shared 6-op logic unit: accepts an operand triple plus
// op mask, steps the select through each requested op and streams the results.
module unidad_logica_secuenciador
   import unidad_logica_secuenciador_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LU_W-1:0]     in_a,
   input  logic [LU_W-1:0]     in_b,
   input  logic [LU_W-1:0]     in_c,
   input  logic [LU_N_OPS-1:0] in_mask,
   output logic [LU_W-1:0]     lu_a,
   output logic [LU_W-1:0]     lu_b,
   output logic [LU_W-1:0]     lu_c,
   output logic [LU_SEL_W-1:0] lu_s,
   input  logic [LU_ZW-1:0]    lu_z,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LU_ZW-1:0]    out_z,
   output logic [LU_SEL_W-1:0] out_sel,
   output logic                out_last,
   output logic                done
);

   lu_state_e           state_q, state_d;
   logic [LU_W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
   logic [LU_N_OPS-1:0] rem_q, rem_d;
   logic [LU_SEL_W-1:0] sel_q, sel_d;
   logic [LU_ZW-1:0]    z_q, z_d;
   logic [LU_SEL_W-1:0] osel_q, osel_d;
   logic                ovalid_q, ovalid_d;
   logic                last_q, last_d;
   logic                done_q, done_d;
   logic                irdy_q, irdy_d;

   logic [LU_N_OPS-1:0] rem_clr_c;
   logic [LU_N_OPS-1:0] enc_in_c;
   logic [LU_SEL_W-1:0] enc_idx_c;
   logic                enc_any_c;
   logic                capture_c;

   // In IDLE the encoder looks at the incoming mask; in RUN at what remains
   // once the op currently on lu_s is retired.
   assign rem_clr_c = rem_q & ~lu_sel_onehot(sel_q);
   assign enc_in_c  = (state_q == LU_ST_IDLE) ? in_mask : rem_clr_c;
   assign capture_c = !ovalid_q || out_ready;

   lu_sel_prio_enc u_prio_enc (
      .mask_i  (enc_in_c),
      .idx_c_o (enc_idx_c),
      .any_c_o (enc_any_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      rem_d    = rem_q;
      sel_d    = sel_q;
      z_d      = z_q;
      osel_d   = osel_q;
      ovalid_d = ovalid_q;
      last_d   = last_q;
      done_d   = 1'b0;

      case (state_q)
         LU_ST_IDLE: begin
            if (in_valid && irdy_q) begin
               a_d   = in_a;
               b_d   = in_b;
               c_d   = in_c;
               rem_d = in_mask;
               sel_d = enc_idx_c;
               if (enc_any_c) state_d = LU_ST_RUN;
               else           done_d  = 1'b1;
            end
         end
         LU_ST_RUN: begin
            // Output slot free or draining this cycle: take the current result.
            if (capture_c) begin
               z_d      = lu_z;
               osel_d   = sel_q;
               ovalid_d = 1'b1;
               last_d   = !enc_any_c;
               rem_d    = rem_clr_c;
               if (enc_any_c) sel_d   = enc_idx_c;
               else           state_d = LU_ST_DRAIN;
            end
         end
         LU_ST_DRAIN: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               last_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = LU_ST_IDLE;
            end
         end
         default: state_d = LU_ST_IDLE;
      endcase

      irdy_d = (state_d == LU_ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= LU_ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         rem_q    <= '0;
         sel_q    <= LU_SEL_0;
         z_q      <= '0;
         osel_q   <= LU_SEL_0;
         ovalid_q <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         irdy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         rem_q    <= rem_d;
         sel_q    <= sel_d;
         z_q      <= z_d;
         osel_q   <= osel_d;
         ovalid_q <= ovalid_d;
         last_q   <= last_d;
         done_q   <= done_d;
         irdy_q   <= irdy_d;
      end
   end

   assign in_ready  = irdy_q;
   assign lu_a      = a_q;
   assign lu_b      = b_q;
   assign lu_c      = c_q;
   assign lu_s      = sel_q;
   assign out_valid = ovalid_q;
   assign out_z     = z_q;
   assign out_sel   = osel_q;
   assign out_last  = last_q;
   assign done      = done_q;

endmodule

// File: tb/tb_unidad_logica_secuenciador.sv
// Bench for the logic-unit sequencer with a stub logic unit z = {s, 5'b0, a}.
module tb_unidad_logica_secuenciador;
   import unidad_logica_secuenciador_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a, in_b, in_c;
   logic [5:0]  in_mask;
   logic [7:0]  lu_a, lu_b, lu_c;
   logic [2:0]  lu_s;
   logic [15:0] lu_z;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_z;
   logic [2:0]  out_sel;
   logic        out_last;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] got_z[$];
   logic [2:0]  got_sel[$];
   logic        got_last[$];
   int          done_edge, done_cnt, stall_err, sel_err, rdy_after_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign lu_z = {lu_s, 5'b0, lu_a};

   unidad_logica_secuenciador dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mask(in_mask),
      .lu_a(lu_a), .lu_b(lu_b), .lu_c(lu_c), .lu_s(lu_s), .lu_z(lu_z),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_sel(out_sel), .out_last(out_last), .done(done)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one command for one accept edge; returns at the negedge after it.
   task automatic send_cmd(input logic [7:0] a, b, c, input logic [5:0] m);
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_mask = m;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom); in_mask = 6'($urandom);
   endtask

   // Observe the result stream. mode 0: ready high, 1: ready 1,0,0,1..., 2: random.
   task automatic collect(input int mode, input int max_cyc);
      logic        stalled;
      logic [15:0] pz;
      logic [2:0]  ps;
      logic        pl;
      got_z.delete(); got_sel.delete(); got_last.delete();
      done_edge = -1; done_cnt = 0; stall_err = 0; sel_err = 0; rdy_after_done = -1;
      stalled = 1'b0; pz = '0; ps = '0; pl = 1'b0;
      for (int e = 1; e <= max_cyc; e++) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (((e - 1) % 4) == 0) || (((e - 1) % 4) == 3);
            default: out_ready = ($urandom_range(0, 9) < 7);
         endcase
         if (stalled && !(out_valid && out_z == pz && out_sel == ps && out_last == pl)) stall_err++;
         if (lu_s > 3'd5) sel_err++;
         if (out_valid && out_ready) begin
            got_z.push_back(out_z); got_sel.push_back(out_sel); got_last.push_back(out_last);
         end
         if (done) begin
            done_cnt++;
            if (done_edge < 0) done_edge = e;
         end
         if (done_edge >= 0 && e == done_edge + 1) rdy_after_done = int'(in_ready);
         stalled = out_valid && !out_ready;
         pz = out_z; ps = out_sel; pl = out_last;
         if (done_edge >= 0 && e >= done_edge + 3) break;
         @(negedge clk);
      end
   endtask

   // Number of differences between the collected stream and the ideal one:
   // every set mask bit, ascending, z = {sel, 5'b0, a}, last on the highest bit.
   function automatic int result_errs(input logic [7:0] a, input logic [5:0] m);
      int errs = 0;
      int idx  = 0;
      for (int k = 0; k < 6; k++) begin
         if (m[k]) begin
            if (idx >= got_z.size()) errs++;
            else begin
               if (got_sel[idx] !== 3'(k)) errs++;
               if (got_z[idx] !== {3'(k), 5'b0, a}) errs++;
               if (got_last[idx] !== (6'(m >> (k + 1)) == 6'd0)) errs++;
            end
            idx++;
         end
      end
      if (got_z.size() != idx) errs++;
      return errs;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_c = '0; in_mask = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if ({out_valid, out_last, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {out_valid, out_last, done}); end
      n_checks++; if ({lu_a, lu_b, lu_c, lu_s} !== 27'd0) begin n_fail++; $display("FAIL reset_lu: got %h want 0", {lu_a, lu_b, lu_c, lu_s}); end
      n_checks++; if ({out_z, out_sel} !== 19'd0) begin n_fail++; $display("FAIL reset_out: got %h want 0", {out_z, out_sel}); end
      rst_n = 1'b1;
   endtask

   task automatic test_all_ops();
      send_cmd(8'd1, 8'd2, 8'd3, 6'b111111);
      collect(0, 30);
      n_checks++; if (result_errs(8'd1, 6'b111111) !== 0) begin n_fail++; $display("FAIL all_ops_stream: %0d diffs want 0", result_errs(8'd1, 6'b111111)); end
      n_checks++; if (got_z.size() != 6 || got_z[0] !== 16'h0001 || got_z[5] !== 16'hA001 || got_sel[5] !== LU_SEL_5)
         begin n_fail++; $display("FAIL all_ops_ends: got %0d results want 6, first 0001 last A001 sel 5", got_z.size()); end
      n_checks++; if (done_edge !== 8) begin n_fail++; $display("FAIL all_ops_done_latency: got %0d want 8", done_edge); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL all_ops_done_count: got %0d want 1", done_cnt); end
      n_checks++; if ({lu_a, lu_b, lu_c} !== {8'd1, 8'd2, 8'd3}) begin n_fail++; $display("FAIL all_ops_operands: got %h want 010203", {lu_a, lu_b, lu_c}); end
   endtask

   task automatic test_sparse_mask();
      send_cmd(8'h7E, 8'h11, 8'h22, 6'b100100);
      collect(0, 30);
      n_checks++; if (got_sel.size() != 2 || got_sel[0] !== LU_SEL_2 || got_sel[1] !== LU_SEL_5)
         begin n_fail++; $display("FAIL sparse_sels: got %0d results want sel 2,5", got_sel.size()); end
      n_checks++; if (got_last.size() != 2 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1)
         begin n_fail++; $display("FAIL sparse_last: got %0d results want last 0,1", got_last.size()); end
      n_checks++; if (result_errs(8'h7E, 6'b100100) !== 0) begin n_fail++; $display("FAIL sparse_stream: %0d diffs want 0", result_errs(8'h7E, 6'b100100)); end
      n_checks++; if (done_edge !== 4) begin n_fail++; $display("FAIL sparse_done_latency: got %0d want 4", done_edge); end
   endtask

   task automatic test_backpressure();
      send_cmd(8'hC3, 8'h01, 8'h02, 6'b111111);
      collect(1, 60);
      n_checks++; if (result_errs(8'hC3, 6'b111111) !== 0) begin n_fail++; $display("FAIL bp_stream: %0d diffs want 0", result_errs(8'hC3, 6'b111111)); end
      n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_err); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
      out_ready = 1'b1;
   endtask

   task automatic test_empty_mask();
      send_cmd(8'h44, 8'h55, 8'h66, 6'b000000);
      collect(0, 10);
      n_checks++; if (got_z.size() !== 0) begin n_fail++; $display("FAIL empty_results: got %0d want 0", got_z.size()); end
      n_checks++; if (done_edge !== 1 || done_cnt !== 1) begin n_fail++; $display("FAIL empty_done: got edge %0d count %0d want 1 1", done_edge, done_cnt); end
      n_checks++; if (rdy_after_done !== 1) begin n_fail++; $display("FAIL empty_ready_after: got %0d want 1", rdy_after_done); end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [7:0] a;
      logic [5:0] m;
      n = 0;
      out_ready = 1'b1;
      send_cmd(8'h5A, 8'h5B, 8'h5C, 6'b111111);
      for (int e = 0; e < 20; e++) begin
         if (out_valid && out_ready) n++;
         if (n == 3) break;
         @(negedge clk);
      end
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      n_checks++; if ({out_valid, out_last, done, in_ready} !== 4'b0001) begin n_fail++; $display("FAIL midreset_state: got %b want 0001", {out_valid, out_last, done, in_ready}); end
      n_checks++; if ({lu_s, lu_a} !== 11'd0) begin n_fail++; $display("FAIL midreset_lu: got %h want 0", {lu_s, lu_a}); end
      a = 8'($urandom); m = 6'($urandom) | 6'b010000;
      send_cmd(a, 8'h00, 8'hFF, m);
      collect(0, 30);
      n_checks++; if (result_errs(a, m) !== 0) begin n_fail++; $display("FAIL midreset_next_stream: %0d diffs want 0", result_errs(a, m)); end
      n_checks++; if (done_edge !== $countones(m) + 2) begin n_fail++; $display("FAIL midreset_next_done: got %0d want %0d", done_edge, $countones(m) + 2); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a1, a2;
      logic [5:0] m1, m2;
      int n1, viol, de;
      a1 = 8'($urandom); a2 = ~a1;
      m1 = 6'($urandom) | 6'b000001; m2 = 6'($urandom) | 6'b100000;
      n1 = 0; viol = 0; de = -1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_a = a1; in_b = a1; in_c = a1; in_mask = m1;
      @(negedge clk);
      in_a = a2; in_b = a2; in_c = a2; in_mask = m2;
      for (int e = 1; e <= 20; e++) begin
         if (done) begin de = e; break; end
         if (in_ready !== 1'b0 || lu_a !== a1) viol++;
         if (out_valid && out_ready) n1++;
         @(negedge clk);
      end
      n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL b2b_hold_off: got %0d violations want 0", viol); end
      n_checks++; if (n1 !== $countones(m1)) begin n_fail++; $display("FAIL b2b_first_count: got %0d want %0d", n1, $countones(m1)); end
      n_checks++; if (de !== $countones(m1) + 2) begin n_fail++; $display("FAIL b2b_first_done: got %0d want %0d", de, $countones(m1) + 2); end
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (lu_a !== a2) begin n_fail++; $display("FAIL b2b_second_accept: got %h want %h", lu_a, a2); end
      collect(0, 30);
      n_checks++; if (result_errs(a2, m2) !== 0) begin n_fail++; $display("FAIL b2b_second_stream: %0d diffs want 0", result_errs(a2, m2)); end
   endtask

   task automatic test_random();
      logic [7:0] a, b, c;
      logic [5:0] m;
      int mode, errs, n;
      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
         m = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
         mode = $urandom_range(0, 2);
         n = $countones(m);
         send_cmd(a, b, c, m);
         collect(mode, 80);
         errs = result_errs(a, m);
         n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL rand_stream[%0d]: %0d diffs want 0 (mask %b)", i, errs, m); end
         n_checks++; if (done_cnt !== 1 || rdy_after_done !== 1) begin n_fail++; $display("FAIL rand_done[%0d]: got count %0d ready %0d want 1 1", i, done_cnt, rdy_after_done); end
         n_checks++; if (stall_err !== 0 || sel_err !== 0) begin n_fail++; $display("FAIL rand_protocol[%0d]: got stall %0d sel %0d want 0 0", i, stall_err, sel_err); end
         n_checks++; if ({lu_b, lu_c} !== {b, c}) begin n_fail++; $display("FAIL rand_operands[%0d]: got %h want %h", i, {lu_b, lu_c}, {b, c}); end
         if (mode == 0) begin
            n_checks++; if (done_edge !== ((n == 0) ? 1 : n + 2)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, done_edge, (n == 0) ? 1 : n + 2); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_ops();
      test_sparse_mask();
      test_backpressure();
      test_empty_mask();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
